// File: rtl/conv_out_collector.sv
// Serializes encoder triples (d0, d1, d2) into a byte stream for the output FIFO.
// Optional trailing XOR checksum byte when COLLECT_CHECKSUM_EN is defined.
module conv_out_collector #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       blk_start,
  input  logic [7:0] blk_meta,
  input  logic       enc_valid,
  input  logic [7:0] enc_d0,
  input  logic [7:0] enc_d1,
  input  logic [7:0] enc_d2,
  output logic       enc_ready,
  input  logic       out_full,
  output logic       out_wrreq,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy,
  output logic       blk_done,
  output logic [9:0] triple_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [9:0]    SIZE_SMALL = 10'd132;
  localparam logic [9:0]    SIZE_LARGE = 10'd768;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CKSUM, S_DONE} state_e;

  state_e          state_q;
  logic [9:0]      size_q;
  logic [9:0]      in_count_q;
  logic [9:0]      triple_count_q;
  logic [1:0]      phase_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     cnt_q;
  logic            blk_done_q;
  logic [23:0]     mem_q [DEPTH];
`ifdef COLLECT_CHECKSUM_EN
  logic [7:0]      xor_q;
`endif

  logic        buf_full;
  logic        buf_empty;
  logic [23:0] head;
  logic [7:0]  head_byte;
  logic        last_data;
  logic        push;
  logic        pop;
  logic        unused_meta;

  assign unused_meta = ^blk_meta[7:1];
  assign buf_full    = (cnt_q == CNT_FULL);
  assign buf_empty   = (cnt_q == '0);
  assign head        = mem_q[rd_ptr_q];
  assign last_data   = (triple_count_q == size_q - 10'd1) && (phase_q == 2'd2);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    head_byte = head[23:16];
    unique case (phase_q)
      2'd0:    head_byte = head[7:0];
      2'd1:    head_byte = head[15:8];
      default: head_byte = head[23:16];
    endcase

    enc_ready = (state_q == S_RUN) && !buf_full && (in_count_q < size_q);
    out_wrreq = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    if (state_q == S_RUN && !buf_empty) begin
      out_data  = head_byte;
      out_wrreq = !out_full;
`ifndef COLLECT_CHECKSUM_EN
      out_last  = !out_full && last_data;
`endif
    end
`ifdef COLLECT_CHECKSUM_EN
    if (state_q == S_CKSUM) begin
      out_data  = xor_q;
      out_wrreq = !out_full;
      out_last  = !out_full;
    end
`endif
  end

  assign push = enc_valid && enc_ready;
  assign pop  = out_wrreq && (state_q == S_RUN) && (phase_q == 2'd2);

  // NOTE: the triple storage is deliberately not reset; the pointers and
  // occupancy count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {enc_d2, enc_d1, enc_d0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      size_q         <= SIZE_SMALL;
      in_count_q     <= '0;
      triple_count_q <= '0;
      phase_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
      blk_done_q     <= 1'b0;
`ifdef COLLECT_CHECKSUM_EN
      xor_q          <= '0;
`endif
    end else begin
      blk_done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (blk_start) begin
            size_q         <= blk_meta[0] ? SIZE_LARGE : SIZE_SMALL;
            in_count_q     <= '0;
            triple_count_q <= '0;
            phase_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            cnt_q          <= '0;
`ifdef COLLECT_CHECKSUM_EN
            xor_q          <= '0;
`endif
            state_q        <= S_RUN;
          end
        end

        S_RUN: begin
          if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (in_count_q < size_q) in_count_q <= in_count_q + 10'd1;
          end
          if (out_wrreq) begin
`ifdef COLLECT_CHECKSUM_EN
            xor_q <= xor_q ^ out_data;
`endif
            if (phase_q == 2'd2) begin
              phase_q  <= 2'd0;
              rd_ptr_q <= rd_ptr_q + PTR_ONE;
              if (triple_count_q < size_q) triple_count_q <= triple_count_q + 10'd1;
              if (last_data) begin
`ifdef COLLECT_CHECKSUM_EN
                state_q    <= S_CKSUM;
`else
                state_q    <= S_DONE;
                blk_done_q <= 1'b1;
`endif
              end
            end else begin
              phase_q <= phase_q + 2'd1;
            end
          end
          // A full buffer blocks push, so push and pop never collide at the limits.
          unique case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CNT_ONE;
            2'b01:   cnt_q <= cnt_q - CNT_ONE;
            default: cnt_q <= cnt_q;
          endcase
        end

`ifdef COLLECT_CHECKSUM_EN
        S_CKSUM: begin
          if (!out_full) begin
            state_q    <= S_DONE;
            blk_done_q <= 1'b1;
          end
        end
`endif

        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign blk_done     = blk_done_q;
  assign triple_count = triple_count_q;

endmodule

// File: tb/tb_conv_out_collector.sv
// Self-checking bench for conv_out_collector: table of block scenarios driven
// through a byte scoreboard, plus a hand-written mid-block reset sequence.
module tb_conv_out_collector;

  localparam int DEPTH = 4;
`ifdef COLLECT_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       blk_start;
  logic [7:0] blk_meta;
  logic       enc_valid;
  logic [7:0] enc_d0, enc_d1, enc_d2;
  logic       enc_ready;
  logic       out_full;
  logic       out_wrreq;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       blk_done;
  logic [9:0] triple_count;

  always #5 clk = ~clk;

  conv_out_collector #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .blk_start    (blk_start),
    .blk_meta     (blk_meta),
    .enc_valid    (enc_valid),
    .enc_d0       (enc_d0),
    .enc_d1       (enc_d1),
    .enc_d2       (enc_d2),
    .enc_ready    (enc_ready),
    .out_full     (out_full),
    .out_wrreq    (out_wrreq),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .blk_done     (blk_done),
    .triple_count (triple_count)
  );

  typedef struct {
    logic [7:0] meta;
    bit         backpressure;
    bit         pattern;
    int         mid_start;
    int         exp_triples;
    int         exp_bytes;
  } vec_t;

  vec_t vecs [4];

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] q_exp [$];
  int         cyc = 0;
  int         acc, pops, bytes_out, last_cyc, first_acc, first_wr, done_cnt;
  logic [7:0] xor_m, last_byte;
  bit         cur_active, cur_bp, cur_pat;
  int         cur_size, cur_bytes;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] gen_byte(input bit pattern, input int idx, input int lane);
    if (pattern) begin
      if (idx != 0) return 8'h00;
      return (lane == 0) ? 8'h11 : (lane == 1) ? 8'h22 : 8'h44;
    end
    return 8'((idx * 37 + lane * 101 + 13) ^ (idx >> 3));
  endfunction

  // One clock cycle: drive at the falling edge, sample 1 ns later, and account
  // for whatever handshakes happen at the following rising edge.
  task automatic step(input bit start_pulse, input logic [7:0] meta);
    logic [7:0] exp;
    @(negedge clk);
    cyc++;
    blk_start = start_pulse;
    blk_meta  = meta;
    out_full  = cur_bp ? ((cyc % 5) < 3) : 1'b0;
    enc_valid = cur_active;
    enc_d0    = gen_byte(cur_pat, acc, 0);
    enc_d1    = gen_byte(cur_pat, acc, 1);
    enc_d2    = gen_byte(cur_pat, acc, 2);
    #1;
    if (cur_active && acc >= cur_size) check("ready_after_last_triple", enc_ready, 0);
    if (enc_valid && enc_ready) begin
      q_exp.push_back(enc_d0);
      q_exp.push_back(enc_d1);
      q_exp.push_back(enc_d2);
      if (acc == 0) first_acc = cyc;
      acc++;
    end
    if (out_wrreq) begin
      check("write_while_full", out_full, 0);
      check("byte_within_block", bytes_out < cur_bytes, 1);
      exp = xor_m;
      if (bytes_out < 3 * cur_size) begin
        if (q_exp.size() == 0) check("scoreboard_has_byte", q_exp.size(), 1);
        else exp = q_exp.pop_front();
        xor_m ^= exp;
        if (bytes_out % 3 == 2) pops++;
      end
      check("out_data", out_data, exp);
      check("out_last", out_last, bytes_out == cur_bytes - 1);
      if (first_wr < 0) first_wr = cyc;
      if (bytes_out == cur_bytes - 1) last_cyc = cyc;
      last_byte = out_data;
      bytes_out++;
    end
    if (cur_active) check("buffer_occupancy_le_depth", (acc - pops) <= DEPTH, 1);
    if (blk_done) begin
      done_cnt++;
      check("blk_done_cycle", cyc, last_cyc + 1);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_enc_ready"}, enc_ready, 0);
    check({tag, "_out_wrreq"}, out_wrreq, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_blk_done"}, blk_done, 0);
    check({tag, "_triple_count"}, triple_count, 0);
  endtask

  task automatic run_block(input vec_t v, input int abort_after);
    int k;
    acc = 0; pops = 0; bytes_out = 0; last_cyc = -10;
    first_acc = -1; first_wr = -1; done_cnt = 0; xor_m = 8'h00;
    q_exp.delete();
    cur_bp = v.backpressure; cur_pat = v.pattern;
    cur_size = v.exp_triples; cur_bytes = v.exp_bytes;
    cur_active = 1'b0;
    step(1'b1, v.meta);
    cur_active = 1'b1;
    step(1'b0, v.meta);
    check("busy_in_run", busy, 1);
    check("triple_count_cleared", triple_count, 0);
    k = 0;
    while (done_cnt == 0 && k < 8000) begin
      k++;
      if (v.mid_start != 0 && k == v.mid_start) step(1'b1, v.meta ^ 8'h01);
      else step(1'b0, v.meta);
      if (abort_after != 0 && acc >= abort_after) return;
    end
    check("blk_done_seen", done_cnt, 1);
    check("bytes_written", bytes_out, v.exp_bytes);
    check("triples_accepted", acc, v.exp_triples);
    check("triple_count_final", triple_count, v.exp_triples);
    if (!v.backpressure) check("first_byte_latency", first_wr, first_acc + 1);
`ifdef COLLECT_CHECKSUM_EN
    if (v.pattern) check("checksum_byte", last_byte, 8'h77);
`endif
    cur_active = 1'b0;
    step(1'b0, v.meta);
    check("busy_after_done", busy, 0);
    check("blk_done_single_pulse", blk_done, 0);
  endtask

  initial begin
    reset = 1'b1; blk_start = 1'b0; blk_meta = 8'h00; enc_valid = 1'b0;
    enc_d0 = 8'h00; enc_d1 = 8'h00; enc_d2 = 8'h00; out_full = 1'b0;
    cur_active = 1'b0; cur_bp = 1'b0; cur_pat = 1'b0; cur_size = 0; cur_bytes = 0;
    acc = 0; pops = 0;

    vecs[0] = '{8'h00, 1'b0, 1'b0, 0,  132, 3 * 132 + EXTRA};
    vecs[1] = '{8'hFD, 1'b0, 1'b0, 0,  768, 3 * 768 + EXTRA};
    vecs[2] = '{8'h00, 1'b1, 1'b0, 0,  132, 3 * 132 + EXTRA};
    vecs[3] = '{8'hFE, 1'b0, 1'b1, 40, 132, 3 * 132 + EXTRA};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_values("por");

    for (int i = 0; i < 4; i++) run_block(vecs[i], 0);

    // Reset after 50 accepted triples, then a fresh block must run cleanly.
    run_block(vecs[0], 50);
    @(negedge clk);
    cyc++;
    reset = 1'b1; blk_start = 1'b0; enc_valid = 1'b0; out_full = 1'b1;
    @(negedge clk);
    cyc++;
    reset = 1'b0; out_full = 1'b0;
    #1;
    check_reset_values("mid_reset");
    run_block(vecs[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
